// File: rtl/step_run_ctrl_if.sv
// rtl/step_run_ctrl_if.sv - front-panel/core signal bundle for the run/step controller
// master drives buttons and halt; slave is the controller producing the enable.
interface step_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             change;
    logic             step;
    logic             halt;
    logic             cpu_en;
    logic             mode;
    logic             halted;
    logic [CNT_W-1:0] tick_count;

    modport master (
        output change, step, halt,
        input  cpu_en, mode, halted, tick_count
    );

    modport slave (
        input  change, step, halt,
        output cpu_en, mode, halted, tick_count
    );
endinterface

// File: rtl/step_run_ctrl.sv
// rtl/step_run_ctrl.sv - run/step clock-enable controller for the single-cycle core
// Buttons are synchronized and debounced; the FSM issues one-cycle cpu_en pulses.
module step_run_ctrl_btn #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic rise_ev
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          deb;
    logic          deb_q;
    logic [DW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb     <= 1'b0;
            deb_q   <= 1'b0;
            rise_ev <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            deb_q   <= deb;
            rise_ev <= deb & ~deb_q;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end
endmodule

module step_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RUN_DIV         = 4,
    parameter int CNT_W           = 32
) (
    input  logic             clock,
    input  logic             reset,
    step_run_ctrl_if.slave   bus
);
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    localparam logic [1:0] ST_STEP_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN       = 2'd1;
    localparam logic [1:0] ST_HALTED    = 2'd2;

    logic             chg_ev;
    logic             stp_ev;
    logic [1:0]       state;
    logic [DIV_W-1:0] div;
    logic             cpu_en_r;
    logic [CNT_W-1:0] tick;

    step_run_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chg (
        .clock   (clock),
        .reset   (reset),
        .raw     (bus.change),
        .rise_ev (chg_ev)
    );

    step_run_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stp (
        .clock   (clock),
        .reset   (reset),
        .raw     (bus.step),
        .rise_ev (stp_ev)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_STEP_IDLE;
            div      <= '0;
            cpu_en_r <= 1'b0;
            tick     <= '0;
        end else begin
            cpu_en_r <= 1'b0;
            case (state)
                ST_STEP_IDLE: begin
                    // A mode change outranks a coincident step press.
                    if (chg_ev) begin
                        state <= ST_RUN;
                        div   <= '0;
                    end else if (stp_ev) begin
                        cpu_en_r <= 1'b1;
                        tick     <= tick + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (chg_ev) begin
                        state <= ST_STEP_IDLE;
                        div   <= '0;
                    end else if (bus.halt) begin
                        state <= ST_HALTED;
                    end else if (div == DIV_W'(RUN_DIV - 1)) begin
                        div      <= '0;
                        cpu_en_r <= 1'b1;
                        tick     <= tick + CNT_W'(1);
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                ST_HALTED: begin
                    if (chg_ev) begin
                        state <= ST_STEP_IDLE;
                        div   <= '0;
                    end
                end
                default: begin
                    state <= ST_STEP_IDLE;
                    div   <= '0;
                end
            endcase
        end
    end

    assign bus.cpu_en     = cpu_en_r;
    assign bus.mode       = (state != ST_STEP_IDLE);
    assign bus.halted     = (state == ST_HALTED);
    assign bus.tick_count = tick;
endmodule

// File: tb/tb_step_run_ctrl.sv
// tb/tb_step_run_ctrl.sv - self-checking bench for step_run_ctrl
// Instance a: RUN_DIV=4, 32-bit count; instance b: RUN_DIV=1, 3-bit count.
module tb_step_run_ctrl;
    localparam int DEB = 4;

    logic clock;
    logic reset;

    step_run_ctrl_if #(.CNT_W(32)) ia ();
    step_run_ctrl_if #(.CNT_W(3))  ib ();

    step_run_ctrl #(.DEBOUNCE_CYCLES(DEB), .RUN_DIV(4), .CNT_W(32)) u_a (
        .clock (clock),
        .reset (reset),
        .bus   (ia)
    );

    step_run_ctrl #(.DEBOUNCE_CYCLES(DEB), .RUN_DIV(1), .CNT_W(3)) u_b (
        .clock (clock),
        .reset (reset),
        .bus   (ib)
    );

    int n_check = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_check++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Model: debounced level flips when the last DEB synchronized samples all disagree
    // with it; a rise is acted on by the FSM two edges later.
    logic [15:0] m_hist [2][2];
    bit          m_deb  [2][2];
    bit [1:0]    m_pend [2][2];
    int          m_st   [2];
    int          m_age  [2];
    bit          m_en   [2];
    longint      m_cnt  [2];

    function automatic int rd_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic longint mask_of(input int i);
        return (i == 0) ? 64'hFFFF_FFFF : 64'h7;
    endfunction

    initial begin
        bit act_c, act_s, en, flip, hlt;
        bit raw [2];
        forever begin
            @(posedge clock);
            for (int i = 0; i < 2; i++) begin
                if (!reset) begin
                    for (int b = 0; b < 2; b++) begin
                        m_hist[i][b] = '0;
                        m_deb[i][b]  = 1'b0;
                        m_pend[i][b] = '0;
                    end
                    m_st[i] = 0; m_age[i] = 0; m_en[i] = 1'b0; m_cnt[i] = 0;
                end else begin
                    raw[0] = (i == 0) ? ia.change : ib.change;
                    raw[1] = (i == 0) ? ia.step   : ib.step;
                    hlt    = (i == 0) ? ia.halt   : ib.halt;
                    act_c  = m_pend[i][0][1];
                    act_s  = m_pend[i][1][1];
                    en     = 1'b0;
                    if (m_st[i] == 0) begin
                        if (act_c) begin m_st[i] = 1; m_age[i] = 0; end
                        else if (act_s) en = 1'b1;
                    end else if (m_st[i] == 1) begin
                        if (act_c) m_st[i] = 0;
                        else if (hlt) m_st[i] = 2;
                        else begin
                            m_age[i]++;
                            en = ((m_age[i] % rd_of(i)) == 0);
                        end
                    end else begin
                        if (act_c) m_st[i] = 0;
                    end
                    m_en[i]  = en;
                    m_cnt[i] = (m_cnt[i] + (en ? 1 : 0)) & mask_of(i);
                    for (int b = 0; b < 2; b++) begin
                        m_hist[i][b] = {m_hist[i][b][14:0], raw[b]};
                        flip = 1'b1;
                        for (int j = 2; j < DEB + 2; j++)
                            if (m_hist[i][b][j] == m_deb[i][b]) flip = 1'b0;
                        m_pend[i][b] = {m_pend[i][b][0], flip & ~m_deb[i][b]};
                        if (flip) m_deb[i][b] = ~m_deb[i][b];
                    end
                end
            end
        end
    end

    // Every-cycle compare, on the falling edge.
    initial begin
        string sfx;
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                sfx = (i == 0) ? "a" : "b";
                if (!reset) begin
                    chk({"rst_cpu_en_", sfx}, (i == 0) ? ia.cpu_en : ib.cpu_en, 0);
                    chk({"rst_mode_", sfx},   (i == 0) ? ia.mode   : ib.mode,   0);
                    chk({"rst_halted_", sfx}, (i == 0) ? ia.halted : ib.halted, 0);
                    chk({"rst_tick_", sfx},   (i == 0) ? longint'(ia.tick_count) : longint'(ib.tick_count), 0);
                end else begin
                    chk({"cpu_en_", sfx}, (i == 0) ? ia.cpu_en : ib.cpu_en, m_en[i]);
                    chk({"mode_", sfx},   (i == 0) ? ia.mode   : ib.mode,   m_st[i] != 0);
                    chk({"halted_", sfx}, (i == 0) ? ia.halted : ib.halted, m_st[i] == 2);
                    chk({"tick_", sfx},   (i == 0) ? longint'(ia.tick_count) : longint'(ib.tick_count), m_cnt[i]);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int     pulses, at, n;
        longint tc0;
        reset = 1'b0;
        ia.change = 1'b0; ia.step = 1'b0; ia.halt = 1'b0;
        ib.change = 1'b0; ib.step = 1'b0; ib.halt = 1'b0;

        // Reset held while inputs toggle.
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            ia.change = ~ia.change; ia.step = ~ia.step; ia.halt = ~ia.halt;
            ib.change = ~ib.change; ib.step = ~ib.step; ib.halt = ~ib.halt;
            #1;
            chk("hold_rst_cpu_en", ia.cpu_en | ib.cpu_en, 0);
            chk("hold_rst_mode", ia.mode | ib.mode, 0);
        end
        cyc(1);
        ia.change = 1'b0; ia.step = 1'b0; ia.halt = 1'b0;
        ib.change = 1'b0; ib.step = 1'b0; ib.halt = 1'b0;
        cyc(1);
        reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            cyc(1);
            if (ia.cpu_en | ib.cpu_en) pulses++;
        end
        chk("idle_pulses", pulses, 0);
        chk("idle_tick_a", ia.tick_count, 0);

        // Single step: pulse seen after the 8th edge counting the first sampling edge as 1.
        ia.step = 1'b1; pulses = 0; at = 0;
        for (int j = 1; j <= 20; j++) begin
            cyc(1);
            if (ia.cpu_en) begin
                pulses++;
                if (at == 0) at = j;
            end
        end
        chk("step_pulses", pulses, 1);
        chk("step_latency", at, 8);
        ia.step = 1'b0;
        cyc(10);
        ia.step = 1'b1;
        cyc(20);
        ia.step = 1'b0;
        chk("step_tick2", ia.tick_count, 2);
        cyc(10);

        // Bounce: 3 high, 3 low, 2 high.
        ia.step = 1'b1; cyc(3);
        ia.step = 1'b0; cyc(3);
        ia.step = 1'b1; cyc(2);
        ia.step = 1'b0; cyc(20);
        chk("bounce_tick", ia.tick_count, 2);

        // Run mode on a, with a step press during RUN.
        ia.change = 1'b1;
        for (n = 0; n < 40 && !ia.mode; n++) cyc(1);
        chk("run_entry_mode", ia.mode, 1);
        tc0 = ia.tick_count; pulses = 0;
        for (int j = 1; j <= 40; j++) begin
            cyc(1);
            if (ia.cpu_en) pulses++;
            if (j == 2)  ia.change = 1'b0;
            if (j == 5)  ia.step = 1'b1;
            if (j == 20) ia.step = 1'b0;
        end
        chk("run_pulses", pulses, 10);
        chk("run_ticks", longint'(ia.tick_count) - tc0, 10);
        cyc(10);
        ia.change = 1'b1;
        for (n = 0; n < 40 && ia.mode; n++) cyc(1);
        chk("run_exit_mode", ia.mode, 0);
        ia.change = 1'b0;
        tc0 = ia.tick_count;
        cyc(20);
        chk("run_stopped_tick", ia.tick_count, tc0);

        // Halt on b (RUN_DIV=1).
        ib.change = 1'b1;
        for (n = 0; n < 40 && !ib.mode; n++) cyc(1);
        chk("halt_run_mode", ib.mode, 1);
        cyc(3);
        ib.change = 1'b0;
        cyc(5);
        ib.halt = 1'b1;
        cyc(1);
        ib.halt = 1'b0;
        chk("halt_halted", ib.halted, 1);
        chk("halt_cpu_en", ib.cpu_en, 0);
        chk("halt_mode", ib.mode, 1);
        tc0 = ib.tick_count;
        cyc(5);
        chk("halt_frozen", ib.tick_count, tc0);
        ib.step = 1'b1; cyc(10);
        ib.step = 1'b0; cyc(10);
        chk("halt_step_ignored", ib.tick_count, tc0);
        chk("halt_still", ib.halted, 1);
        ib.change = 1'b1;
        for (n = 0; n < 40 && ib.mode; n++) cyc(1);
        chk("unhalt_mode", ib.mode, 0);
        chk("unhalt_halted", ib.halted, 0);
        ib.change = 1'b0;
        cyc(10);

        // Wrap: 9 ticks on a 3-bit counter from reset.
        reset = 1'b0; cyc(2);
        reset = 1'b1; cyc(2);
        chk("wrap_start", ib.tick_count, 0);
        ib.change = 1'b1;
        for (n = 0; n < 40 && !ib.mode; n++) cyc(1);
        ib.change = 1'b0;
        chk("wrap_entry_tick", ib.tick_count, 0);
        cyc(9);
        chk("wrap_tick", ib.tick_count, 1);
        chk("wrap_running", ib.cpu_en, 1);

        // Asynchronous reset mid-run drops cpu_en before the next edge.
        #1 reset = 1'b0;
        #1;
        chk("async_cpu_en", ib.cpu_en, 0);
        chk("async_tick", ib.tick_count, 0);
        chk("async_mode", ib.mode, 0);
        cyc(1);
        reset = 1'b1;
        cyc(3);

        // Simultaneous change+step in STEP_IDLE.
        ib.change = 1'b1; ib.step = 1'b1; pulses = 0;
        for (n = 0; n < 40 && !ib.mode; n++) begin
            cyc(1);
            if (ib.cpu_en) pulses++;
        end
        chk("simul_mode", ib.mode, 1);
        chk("simul_no_step", pulses, 0);
        chk("simul_entry_tick", ib.tick_count, 0);
        cyc(1);
        chk("simul_first_run_tick", ib.cpu_en, 1);
        chk("simul_tick1", ib.tick_count, 1);
        ib.change = 1'b0; ib.step = 1'b0;
        cyc(20);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end
endmodule
